// File: rtl/u2_pkg.sv
// Shared constants and the packed double layout for the U2 fixed-point path.
package u2_pkg;

   localparam int IW   = 10;
   localparam int FW   = 95;
   localparam int MW   = IW + FW;
   localparam int DW   = 64;
   localparam int EW   = 11;
   localparam int MANW = 52;
   localparam int BIAS = 1023;
   localparam int LW   = 7;

   typedef struct packed {
      logic            sign;
      logic [EW-1:0]   exp;
      logic [MANW-1:0] mant;
   } dbl_t;

endpackage

// File: rtl/u2_lzd.sv
// Combinational leading-one detector over the full fixed-point magnitude.
module u2_lzd
   import u2_pkg::*;
(
   input  logic [MW-1:0] mag,
   output logic [LW-1:0] msb,
   output logic          zero
);

   // Ascending scan: the last set bit seen wins, leaving the highest index.
   always_comb begin
      msb  = {LW{1'b0}};
      zero = ~|mag;
      for (int i = 0; i < MW; i++) begin
         msb = mag[i] ? LW'(i) : msb;
      end
   end

endmodule

// File: rtl/u2_renorm.sv
// Three-stage fixed-point to IEEE-754 double normalizer: capture, leading-one
// detect, then normalize / round-to-nearest-even / pack.
module u2_renorm
   import u2_pkg::*;
#(
   parameter int IW   = u2_pkg::IW,
   parameter int FW   = u2_pkg::FW,
   parameter int BIAS = u2_pkg::BIAS
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pushin,
   input  logic          sign_in,
   input  logic [IW-1:0] v_in,
   input  logic [FW-1:0] delta_in,
   output logic          pushout,
   output logic [DW-1:0] z
);

   localparam int W = IW + FW;

   logic          s1_vld_q, s1_vld_d, s1_sign_q, s1_sign_d;
   logic [W-1:0]  s1_mag_q, s1_mag_d;
   logic          s2_vld_q, s2_vld_d, s2_sign_q, s2_sign_d, s2_zero_q, s2_zero_d;
   logic [W-1:0]  s2_mag_q, s2_mag_d;
   logic [LW-1:0] s2_msb_q, s2_msb_d;
   logic          pushout_q, pushout_d;
   logic [DW-1:0] z_q, z_d;

   logic [LW-1:0]   lzd_msb_s;
   logic            lzd_zero_s;
   logic [LW-1:0]   shamt_s;
   logic [W-1:0]    norm_s;
   logic [MANW-1:0] mant_s;
   logic            guard_s, sticky_s, rnd_s;
   logic [MANW:0]   mant_rnd_s;
   logic [EW-1:0]   exp_s;
   dbl_t            res_s;

   u2_lzd u_lzd (
      .mag  (s1_mag_q),
      .msb  (lzd_msb_s),
      .zero (lzd_zero_s)
   );

   // Stage 1/2 next state; data only moves on a valid so idle inputs never leak in.
   always_comb begin
      s1_vld_d  = pushin;
      s1_sign_d = s1_sign_q;
      s1_mag_d  = s1_mag_q;
      if (pushin) begin
         s1_sign_d = sign_in;
         s1_mag_d  = {v_in, delta_in};
      end else begin
         s1_sign_d = s1_sign_q;
         s1_mag_d  = s1_mag_q;
      end
      s2_vld_d  = s1_vld_q;
      s2_sign_d = s2_sign_q;
      s2_mag_d  = s2_mag_q;
      s2_msb_d  = s2_msb_q;
      s2_zero_d = s2_zero_q;
      if (s1_vld_q) begin
         s2_sign_d = s1_sign_q;
         s2_mag_d  = s1_mag_q;
         s2_msb_d  = lzd_msb_s;
         s2_zero_d = lzd_zero_s;
      end else begin
         s2_sign_d = s2_sign_q;
         s2_mag_d  = s2_mag_q;
         s2_msb_d  = s2_msb_q;
         s2_zero_d = s2_zero_q;
      end
   end

   // Stage 3: hidden one to the top, 52-bit mantissa, guard, then sticky below.
   always_comb begin
      shamt_s    = LW'(W - 1) - s2_msb_q;
      norm_s     = s2_mag_q << shamt_s;
      mant_s     = norm_s[W-2 -: MANW];
      guard_s    = norm_s[W-2-MANW];
      sticky_s   = |norm_s[W-3-MANW:0];
      rnd_s      = guard_s & (sticky_s | mant_s[0]);
      mant_rnd_s = {1'b0, mant_s} + {{MANW{1'b0}}, rnd_s};
      // A mantissa carry-out leaves the low 52 bits at zero, so only exp moves.
      exp_s      = EW'(BIAS - FW) + {{(EW-LW){1'b0}}, s2_msb_q}
                 + {{(EW-1){1'b0}}, mant_rnd_s[MANW]};
      res_s.sign = s2_sign_q;
      res_s.exp  = exp_s;
      res_s.mant = mant_rnd_s[MANW-1:0];
      if (s2_zero_q) begin
         res_s.exp  = {EW{1'b0}};
         res_s.mant = {MANW{1'b0}};
      end else begin
         res_s.exp  = exp_s;
         res_s.mant = mant_rnd_s[MANW-1:0];
      end
      pushout_d = s2_vld_q;
      z_d       = z_q;
      if (s2_vld_q) begin
         z_d = res_s;
      end else begin
         z_d = z_q;
      end
   end

   // Pipeline registers; reset discards everything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q  <= 1'b0;
         s1_sign_q <= 1'b0;
         s1_mag_q  <= {W{1'b0}};
         s2_vld_q  <= 1'b0;
         s2_sign_q <= 1'b0;
         s2_mag_q  <= {W{1'b0}};
         s2_msb_q  <= {LW{1'b0}};
         s2_zero_q <= 1'b0;
         pushout_q <= 1'b0;
         z_q       <= {DW{1'b0}};
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_sign_q <= s1_sign_d;
         s1_mag_q  <= s1_mag_d;
         s2_vld_q  <= s2_vld_d;
         s2_sign_q <= s2_sign_d;
         s2_mag_q  <= s2_mag_d;
         s2_msb_q  <= s2_msb_d;
         s2_zero_q <= s2_zero_d;
         pushout_q <= pushout_d;
         z_q       <= z_d;
      end
   end

   assign pushout = pushout_q;
   assign z       = z_q;

endmodule

// File: tb/tb_u2_renorm.sv
// Directed bench for u2_renorm: hand-computed doubles, a streaming burst
// checked against real-number arithmetic, and mid-burst reset.
module tb_u2_renorm;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pushin = 1'b0;
   logic          sign_in = 1'b0;
   logic [9:0]    v_in = 10'd0;
   logic [94:0]   delta_in = 95'd0;
   logic          pushout;
   logic [63:0]   z;

   int n_pass  = 0;
   int n_total = 0;

   logic          ssgn [8];
   logic [104:0]  smag [8];
   logic [63:0]   sexp [8];

   always #5 clk = ~clk;

   u2_renorm dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pushin   (pushin),
      .sign_in  (sign_in),
      .v_in     (v_in),
      .delta_in (delta_in),
      .pushout  (pushout),
      .z        (z)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
   endtask

   task automatic drive(input logic s, input logic [104:0] mag);
      @(negedge clk);
      pushin   = 1'b1;
      sign_in  = s;
      v_in     = mag[104:95];
      delta_in = mag[94:0];
   endtask

   // One isolated conversion: silent after one edge, valid after the third.
   task automatic single(input string tag, input logic s, input logic [104:0] mag,
                         input logic [63:0] expz);
      drive(s, mag);
      @(posedge clk); #1;
      pushin = 1'b0;
      @(posedge clk); #1;
      check({tag, "_early"}, {63'd0, pushout}, 64'd0);
      @(posedge clk); #1;
      check({tag, "_vld"}, {63'd0, pushout}, 64'd1);
      check(tag, z, expz);
   endtask

   // Random exactly-representable value (<=53 significant bits) and its double.
   task automatic rnd_vec(output logic s, output logic [104:0] mag, output logic [63:0] e);
      longint m;
      int     sh;
      real    r;
      m   = longint'({$urandom, $urandom} & 64'h001F_FFFF_FFFF_FFFF) | 64'd1;
      sh  = $urandom_range(52, 0);
      mag = 105'(m) << sh;
      r   = real'(m);
      for (int j = 0; j < 95 - sh; j++) r = r / 2.0;
      s = 1'($urandom_range(1, 0));
      if (s) r = -r;
      e = $realtobits(r);
   endtask

   initial begin
      logic [104:0] one;
      logic         ts;
      logic [104:0] tm;
      logic [63:0]  te;
      one = 105'd1 << 95;

      #3;
      check("rst_pushout", {63'd0, pushout}, 64'd0);
      check("rst_z", z, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      single("one",      1'b0, one,                             64'h3FF0000000000000);
      single("one_half", 1'b0, one | (105'd1 << 94),            64'h3FF8000000000000);
      single("neg_1p5",  1'b1, one | (105'd1 << 94),            64'hBFF8000000000000);
      single("pos_zero", 1'b0, 105'd0,                          64'h0000000000000000);
      single("neg_zero", 1'b1, 105'd0,                          64'h8000000000000000);
      single("smallest", 1'b0, 105'd1,                          64'h3A00000000000000);
      single("tie_even", 1'b0, one | (105'd1 << 42),            64'h3FF0000000000000);
      single("tie_odd",  1'b0, one | (105'd3 << 42),            64'h3FF0000000000002);
      single("above_tie",1'b0, one | (105'd1 << 42) | 105'd1,   64'h3FF0000000000001);
      single("carry",    1'b0, {105{1'b1}},                     64'h4090000000000000);

      for (int i = 0; i < 8; i++) begin
         rnd_vec(ts, tm, te);
         ssgn[i] = ts;
         smag[i] = tm;
         sexp[i] = te;
      end
      for (int i = 0; i < 11; i++) begin
         if (i < 8) begin
            drive(ssgn[i], smag[i]);
         end else begin
            @(negedge clk);
            pushin = 1'b0;
         end
         @(posedge clk); #1;
         if (i >= 2 && i < 10) begin
            check($sformatf("stream_vld%0d", i - 2), {63'd0, pushout}, 64'd1);
            check($sformatf("stream_z%0d", i - 2), z, sexp[i - 2]);
         end else begin
            check($sformatf("stream_idle%0d", i), {63'd0, pushout}, 64'd0);
         end
      end

      for (int i = 0; i < 5; i++) begin
         rnd_vec(ts, tm, te);
         drive(ts, tm);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      pushin = 1'b0;
      #1;
      check("midrst_pushout", {63'd0, pushout}, 64'd0);
      check("midrst_z", z, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("post_rst_stale%0d", i), {63'd0, pushout}, 64'd0);
      end
      single("post_rst_one", 1'b0, one, 64'h3FF0000000000000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
